// File: rtl/booth_radix4_mult_param.sv
// Sequential radix-4 (modified Booth) multiplier, WIDTH-bit operands, signed or unsigned.
// Two multiplier bits are retired per clock. Both modes run WIDTH/2+1 steps so the latency
// does not depend on the mode. The handshake is start/busy/done, and the product register
// holds its value until the next done.
module booth_radix4_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   outResult
);

    // Operands are widened by two bits so that the unsigned and signed cases share one
    // signed datapath: a zero-extended unsigned value is a non-negative signed value.
    localparam int W2 = WIDTH + 2;
    localparam int N  = W2 / 2;
    localparam int AW = W2 + 2;       // room for +/-2M without overflow
    localparam int CW = $clog2(N + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("booth_radix4_mult_param: WIDTH must be even and >= 4");
        end
    endgenerate

    logic [0:0]         state_q, state_d;
    logic [W2-1:0]      m_q, m_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [W2-1:0]      q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [W2-1:0]      a_ext, b_ext;
    logic [AW-1:0]      m_sx, m2_sx, term, acc_sum, acc_shift;
    logic [W2-1:0]      q_shift;
    logic               qm1_shift;
    logic               last_step;

    // Operand extension: sign bits replicate only in signed mode.
    always_comb begin
        a_ext = {{2{signed_mode & inputA[WIDTH-1]}}, inputA};
        b_ext = {{2{signed_mode & inputB[WIDTH-1]}}, inputB};
    end

    // One Booth step: select the term from {Q[1],Q[0],q_m1}, add it, then shift right by 2.
    always_comb begin
        m_sx  = {{2{m_q[W2-1]}}, m_q};
        m2_sx = m_sx << 1;
        unique case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: term = m_sx;
            3'b011:         term = m2_sx;
            3'b100:         term = -m2_sx;
            3'b101, 3'b110: term = -m_sx;
            default:        term = '0;
        endcase
        acc_sum   = acc_q + term;
        // Arithmetic shift of the whole {ACC,Q,q_m1} chain.
        acc_shift = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        q_shift   = {acc_sum[1:0], q_q[W2-1:2]};
        qm1_shift = q_q[1];
        last_step = (cnt_q == CW'(N - 1));
    end

    // Next-state logic for the IDLE/RUN controller and the datapath registers.
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a_ext;
                    q_d     = b_ext;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_shift;
                q_d   = q_shift;
                qm1_d = qm1_shift;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    // Low 2*WIDTH bits of the final {ACC,Q}; the upper bits are sign copies.
                    result_d = {acc_shift[WIDTH-3:0], q_shift};
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            m_q      <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign outResult = result_q;

endmodule
